// File: rtl/jk_mod_counter_if.sv
// ---------------------------------------------------------------------------
// jk_mod_counter_if
//
// Purpose:
//   Bundles the control, data and status signals of one jk_mod_counter
//   digit, so a digit can be passed around as a single port. Clock and
//   reset are not part of the bundle; they stay plain ports on the counter.
//
// Parameters:
//   WIDTH   number of state bits; must match the WIDTH of the counter
//
// Signals:
//   en      count enable                       (master -> slave)
//   up      direction, 1 = increment           (master -> slave)
//   load    synchronous parallel load          (master -> slave)
//   d       load value, WIDTH bits             (master -> slave)
//   q       counter state, WIDTH bits          (slave  -> master)
//   tc      terminal count, combinational      (slave  -> master)
//   wrap    one-cycle pulse after a wrap edge  (slave  -> master)
//   j_vec   registered J excitation            (slave  -> master, optional)
//   k_vec   registered K excitation            (slave  -> master, optional)
//
// Build option:
//   JK_EXCITE_OUT_EN  when defined, j_vec/k_vec exist in the bundle.
// ---------------------------------------------------------------------------
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
`ifdef JK_EXCITE_OUT_EN
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
`endif

    // The side that drives the counter (a bench or an upstream controller).
    modport master (
        output en,
        output up,
        output load,
        output d,
        input  q,
        input  tc,
`ifdef JK_EXCITE_OUT_EN
        input  j_vec,
        input  k_vec,
`endif
        input  wrap
    );

    // The counter itself.
    modport slave (
        input  en,
        input  up,
        input  load,
        input  d,
        output q,
        output tc,
`ifdef JK_EXCITE_OUT_EN
        output j_vec,
        output k_vec,
`endif
        output wrap
    );
endinterface

// File: rtl/jk_mod_counter.sv
// ---------------------------------------------------------------------------
// jk_mod_counter
//
// Purpose:
//   Synchronous modulo-MODULO up/down counter. Every state bit is modelled
//   as a JK cell: the next state is computed first, then the J/K excitation
//   that moves each bit from its current to its next value is derived, and
//   the bits are updated with JK semantics (00 hold, 10 set, 01 clear,
//   11 toggle). A combinational terminal count and a registered wrap pulse
//   allow digits to be cascaded (e.g. BCD), with the upper digit's enable
//   taken from the lower digit's tc.
//
// Parameters:
//   WIDTH    number of state bits / JK cells            (default 4)
//   MODULO   count modulus, legal range 2..2**WIDTH     (default 10)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   bus      jk_mod_counter_if.slave
//              en, up, load, d  : control and load value (inputs)
//              q                : counter state
//              tc               : en & (up ? q==MODULO-1 : q==0)
//              wrap             : high for the cycle after a wrapping edge
//              j_vec, k_vec     : excitation of the latest edge (optional)
//
// Priority at each edge: reset, then load, then count, then hold.
//
// Build option:
//   JK_EXCITE_OUT_EN  when defined, the registered J/K excitation vectors
//                     are driven onto bus.j_vec / bus.k_vec. Counting
//                     behaviour is the same with or without it.
// ---------------------------------------------------------------------------
module jk_mod_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    jk_mod_counter_if.slave     bus
);

    // One extra bit so MODULO == 2**WIDTH is representable for the
    // "is this value out of range" comparisons.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] Q_ZERO  = '0;

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] nxt;
    logic             wrap_nxt;
    logic [WIDTH-1:0] d_clamped;
    logic             q_illegal;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q_jk;

    // Applies JK cell semantics bit by bit. The 11 (toggle) case is kept
    // for completeness of the cell model, though the excitation mapping
    // below never produces it.
    function automatic logic [WIDTH-1:0] jk_apply(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] jv,
        input logic [WIDTH-1:0] kv
    );
        logic [WIDTH-1:0] res;
        res = cur;
        for (int i = 0; i < WIDTH; i++) begin
            case ({jv[i], kv[i]})
                2'b10:   res[i] = 1'b1;
                2'b01:   res[i] = 1'b0;
                2'b11:   res[i] = ~cur[i];
                default: res[i] = cur[i];
            endcase
        end
        return res;
    endfunction

    // Load values at or beyond the modulus are pulled back to the top
    // legal state so a load can never create an out-of-range state.
    assign d_clamped = ({1'b0, bus.d} >= MOD_EXT) ? Q_MAX : bus.d;

    // Only reachable if the state is forced from outside; used to recover
    // to a legal state on the next counting edge without a wrap pulse.
    assign q_illegal = ({1'b0, q_r} >= MOD_EXT);

    // Next-state computation. This is the value the JK cells must land on;
    // wrap_nxt flags a genuine modulo boundary crossing (not recovery from
    // an illegal state, and never on load, hold or reset).
    always_comb begin
        nxt      = q_r;
        wrap_nxt = 1'b0;
        if (!rst_n) begin
            nxt = Q_ZERO;
        end else if (bus.load) begin
            nxt = d_clamped;
        end else if (bus.en) begin
            if (bus.up) begin
                if (q_illegal) begin
                    nxt = Q_ZERO;
                end else if (q_r == Q_MAX) begin
                    nxt      = Q_ZERO;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = q_r + WIDTH'(1);
                end
            end else begin
                if (q_illegal) begin
                    nxt = Q_MAX;
                end else if (q_r == Q_ZERO) begin
                    nxt      = Q_MAX;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = q_r - WIDTH'(1);
                end
            end
        end
    end

    // Excitation: set bits that must rise, clear bits that must fall, leave
    // the rest alone. J and K are therefore never both high on one bit.
    // During reset every cell is driven with a clear (J=0, K=1) instead.
    always_comb begin
        if (!rst_n) begin
            j = '0;
            k = '1;
        end else begin
            j = ~q_r & nxt;
            k = q_r & ~nxt;
        end
    end

    // Result of clocking the JK cells with the excitation above; equals
    // nxt by construction.
    assign q_jk = jk_apply(q_r, j, k);

    // State register. The cells take their JK result every edge (reset is
    // already folded into the excitation); the wrap pulse is cleared while
    // rst_n is low.
    always_ff @(posedge clk) begin
        q_r <= q_jk;
        if (!rst_n) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= wrap_nxt;
        end
    end

`ifdef JK_EXCITE_OUT_EN
    logic [WIDTH-1:0] j_vec_r;
    logic [WIDTH-1:0] k_vec_r;

    // Registered copy of the excitation applied at the latest edge. After
    // reset these read zero rather than the internal clear pattern, so an
    // external cell driven from them is simply left alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            j_vec_r <= '0;
            k_vec_r <= '0;
        end else begin
            j_vec_r <= j;
            k_vec_r <= k;
        end
    end

    assign bus.j_vec = j_vec_r;
    assign bus.k_vec = k_vec_r;
`endif

    // Terminal count is combinational so a cascaded digit using it as its
    // enable advances on the same edge as this digit wraps.
    assign bus.tc   = bus.en & (bus.up ? (q_r == Q_MAX) : (q_r == Q_ZERO));
    assign bus.q    = q_r;
    assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_jk_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_mod_counter
//
// Purpose:
//   Self-checking bench for jk_mod_counter. Drives a default MODULO=10
//   instance with directed and randomized stimulus checked against a plain
//   arithmetic model, plus a MODULO=2 instance for consecutive wraps, a
//   MODULO=16 instance for natural binary wrap, and two cascaded decade
//   digits. Build with JK_EXCITE_OUT_EN defined to also check j_vec/k_vec.
// ---------------------------------------------------------------------------
module tb_jk_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic aux_rst_n;
    logic c_rst_n;

    jk_mod_counter_if #(.WIDTH(4)) m_if ();
    jk_mod_counter_if #(.WIDTH(4)) a2_if ();
    jk_mod_counter_if #(.WIDTH(4)) a16_if ();
    jk_mod_counter_if #(.WIDTH(4)) lo_if ();
    jk_mod_counter_if #(.WIDTH(4)) hi_if ();

    jk_mod_counter #(.WIDTH(4), .MODULO(10)) dut     (.clk(clk), .rst_n(rst_n),     .bus(m_if));
    jk_mod_counter #(.WIDTH(4), .MODULO(2))  dut_m2  (.clk(clk), .rst_n(aux_rst_n), .bus(a2_if));
    jk_mod_counter #(.WIDTH(4), .MODULO(16)) dut_m16 (.clk(clk), .rst_n(aux_rst_n), .bus(a16_if));
    jk_mod_counter #(.WIDTH(4), .MODULO(10)) dut_lo  (.clk(clk), .rst_n(c_rst_n),   .bus(lo_if));
    jk_mod_counter #(.WIDTH(4), .MODULO(10)) dut_hi  (.clk(clk), .rst_n(c_rst_n),   .bus(hi_if));

    // Cascade: the upper digit counts whenever the lower one is at terminal.
    assign hi_if.en = lo_if.tc;

    int   errors = 0;
    int   checks = 0;

    int   mq;
    logic mwrap;
    int   m2q;
    logic m2wrap;
    int   m16q;
    logic m16wrap;
`ifdef JK_EXCITE_OUT_EN
    logic [3:0] mj;
    logic [3:0] mk;
`endif

    // Reference behaviour in plain modular arithmetic.
    function automatic void model_next(input int mod, input int cur, input logic rn,
                                       input logic ld, input logic e, input logic u,
                                       input int dv, output int nq, output logic nw);
        nw = 1'b0;
        nq = cur;
        if (!rn) begin
            nq = 0;
        end else if (ld) begin
            nq = (dv >= mod) ? mod - 1 : dv;
        end else if (e) begin
            if (u) begin
                nw = (cur == mod - 1);
                nq = (cur + 1) % mod;
            end else begin
                nw = (cur == 0);
                nq = (cur + mod - 1) % mod;
            end
        end
    endfunction

    function automatic logic exp_tc(input int mod, input int cur, input logic e, input logic u);
        return e && (u ? (cur == mod - 1) : (cur == 0));
    endfunction

    // Advances the main instance one edge, keeping the model in step.
    task automatic tick();
        int   nq;
        logic nw;
`ifdef JK_EXCITE_OUT_EN
        logic [3:0] p4;
        logic [3:0] n4;
`endif
        model_next(10, mq, rst_n, m_if.load, m_if.en, m_if.up, int'(m_if.d), nq, nw);
`ifdef JK_EXCITE_OUT_EN
        p4 = 4'(mq);
        n4 = 4'(nq);
        if (!rst_n) begin
            mj = '0;
            mk = '0;
        end else begin
            mj = ~p4 & n4;
            mk = p4 & ~n4;
        end
`endif
        @(posedge clk);
        mq    = nq;
        mwrap = nw;
        @(negedge clk);
    endtask

    // Advances the MODULO=2 and MODULO=16 instances one edge.
    task automatic tick_aux();
        int   n2;
        int   n16;
        logic w2;
        logic w16;
        model_next(2, m2q, aux_rst_n, a2_if.load, a2_if.en, a2_if.up, int'(a2_if.d), n2, w2);
        model_next(16, m16q, aux_rst_n, a16_if.load, a16_if.en, a16_if.up, int'(a16_if.d), n16, w16);
        @(posedge clk);
        m2q = n2;   m2wrap = w2;
        m16q = n16; m16wrap = w16;
        @(negedge clk);
    endtask

    task automatic tick_c();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_if.en = 1'b0; m_if.up = 1'b1; m_if.load = 1'b0; m_if.d = 4'd0;
        tick();
        tick();
        checks++;
        if (m_if.q !== 4'd0) begin errors++; $display("[TB] FAIL reset_q: got %0d expected 0", m_if.q); end
        checks++;
        if (m_if.wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap: got %0b expected 0", m_if.wrap); end
`ifdef JK_EXCITE_OUT_EN
        checks++;
        if (m_if.j_vec !== 4'd0 || m_if.k_vec !== 4'd0) begin
            errors++; $display("[TB] FAIL reset_jk: got j=%b k=%b expected 0000/0000", m_if.j_vec, m_if.k_vec);
        end
`endif
        m_if.en = 1'b1; m_if.up = 1'b0; #1;
        checks++;
        if (m_if.tc !== 1'b1) begin errors++; $display("[TB] FAIL reset_tc_down: got %0b expected 1", m_if.tc); end
        m_if.up = 1'b1; #1;
        checks++;
        if (m_if.tc !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc_up: got %0b expected 0", m_if.tc); end
        m_if.en = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        m_if.en = 1'b1; m_if.up = 1'b1; m_if.load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (m_if.tc !== (i == 9)) begin errors++; $display("[TB] FAIL up_tc: got %0b expected %0b at step %0d", m_if.tc, (i == 9), i); end
            tick();
            checks++;
            if (m_if.q !== 4'((i + 1) % 10)) begin errors++; $display("[TB] FAIL up_q: got %0d expected %0d", m_if.q, (i + 1) % 10); end
            checks++;
            if (m_if.wrap !== (i == 9)) begin errors++; $display("[TB] FAIL up_wrap: got %0b expected %0b at step %0d", m_if.wrap, (i == 9), i); end
        end
    endtask

    task automatic test_count_down();
        m_if.en = 1'b1; m_if.up = 1'b0; m_if.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (m_if.tc !== (i == 0)) begin errors++; $display("[TB] FAIL down_tc: got %0b expected %0b at step %0d", m_if.tc, (i == 0), i); end
            tick();
            checks++;
            if (m_if.q !== 4'(9 - i)) begin errors++; $display("[TB] FAIL down_q: got %0d expected %0d", m_if.q, 9 - i); end
            checks++;
            if (m_if.wrap !== (i == 0)) begin errors++; $display("[TB] FAIL down_wrap: got %0b expected %0b at step %0d", m_if.wrap, (i == 0), i); end
        end
    endtask

    task automatic test_load();
        m_if.en = 1'b0; m_if.load = 1'b1; m_if.d = 4'd7;
        tick();
        checks++;
        if (m_if.q !== 4'd7) begin errors++; $display("[TB] FAIL load_q: got %0d expected 7", m_if.q); end
        m_if.d = 4'd12;
        tick();
        checks++;
        if (m_if.q !== 4'd9) begin errors++; $display("[TB] FAIL load_clamp: got %0d expected 9", m_if.q); end
        m_if.en = 1'b1; m_if.up = 1'b1; m_if.d = 4'd3;
        tick();
        checks++;
        if (m_if.q !== 4'd3) begin errors++; $display("[TB] FAIL load_over_en: got %0d expected 3", m_if.q); end
        checks++;
        if (m_if.wrap !== 1'b0) begin errors++; $display("[TB] FAIL load_wrap: got %0b expected 0", m_if.wrap); end
        m_if.load = 1'b0; m_if.en = 1'b0;
    endtask

    task automatic test_reset_priority();
        m_if.load = 1'b1; m_if.d = 4'd5; m_if.en = 1'b0;
        tick();
        m_if.load = 1'b0; m_if.en = 1'b1; m_if.up = 1'b1;
        tick();
        checks++;
        if (m_if.q !== 4'd6) begin errors++; $display("[TB] FAIL prio_setup: got %0d expected 6", m_if.q); end
        rst_n = 1'b0; m_if.load = 1'b1; m_if.d = 4'd2;
        tick();
        checks++;
        if (m_if.q !== 4'd0) begin errors++; $display("[TB] FAIL prio_q: got %0d expected 0", m_if.q); end
        checks++;
        if (m_if.wrap !== 1'b0) begin errors++; $display("[TB] FAIL prio_wrap: got %0b expected 0", m_if.wrap); end
        rst_n = 1'b1; m_if.load = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (m_if.q !== 4'(i)) begin errors++; $display("[TB] FAIL prio_resume: got %0d expected %0d", m_if.q, i); end
        end
        m_if.en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst_n     = ($urandom_range(0, 15) != 0);
            m_if.load = ($urandom_range(0, 5) == 0);
            m_if.en   = ($urandom_range(0, 3) != 0);
            m_if.up   = 1'($urandom_range(0, 1));
            m_if.d    = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (m_if.tc !== exp_tc(10, mq, m_if.en, m_if.up)) begin
                errors++; $display("[TB] FAIL rand_tc: got %0b expected %0b (q=%0d)", m_if.tc, exp_tc(10, mq, m_if.en, m_if.up), mq);
            end
            tick();
            checks++;
            if (m_if.q !== 4'(mq)) begin errors++; $display("[TB] FAIL rand_q: got %0d expected %0d", m_if.q, mq); end
            checks++;
            if (m_if.wrap !== mwrap) begin errors++; $display("[TB] FAIL rand_wrap: got %0b expected %0b", m_if.wrap, mwrap); end
`ifdef JK_EXCITE_OUT_EN
            checks++;
            if (m_if.j_vec !== mj || m_if.k_vec !== mk) begin
                errors++; $display("[TB] FAIL rand_jk: got j=%b k=%b expected j=%b k=%b", m_if.j_vec, m_if.k_vec, mj, mk);
            end
            checks++;
            if ((m_if.j_vec & m_if.k_vec) !== 4'd0) begin
                errors++; $display("[TB] FAIL rand_jk_overlap: got %b expected 0000", m_if.j_vec & m_if.k_vec);
            end
`endif
        end
        rst_n = 1'b1; m_if.load = 1'b0; m_if.en = 1'b0;
    endtask

    task automatic test_back_to_back();
        aux_rst_n = 1'b0;
        a2_if.en = 1'b0;  a2_if.up = 1'b1;  a2_if.load = 1'b0;  a2_if.d = 4'd0;
        a16_if.en = 1'b0; a16_if.up = 1'b1; a16_if.load = 1'b0; a16_if.d = 4'd0;
        tick_aux();
        aux_rst_n = 1'b1;
        a2_if.load = 1'b1; a2_if.d = 4'd1;
        tick_aux();
        a2_if.load = 1'b0; a2_if.en = 1'b1;
        // Alternating direction from q=1 crosses the boundary on every edge.
        for (int i = 0; i < 6; i++) begin
            a2_if.up = ((i % 2) == 0);
            tick_aux();
            checks++;
            if (a2_if.q !== 4'(m2q)) begin errors++; $display("[TB] FAIL b2b_q: got %0d expected %0d", a2_if.q, m2q); end
            checks++;
            if (a2_if.wrap !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wrap: got %0b expected 1 at step %0d", a2_if.wrap, i); end
        end
        a2_if.up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_aux();
            checks++;
            if (a2_if.wrap !== m2wrap || a2_if.q !== 4'(m2q)) begin
                errors++; $display("[TB] FAIL m2_up: got q=%0d wrap=%0b expected q=%0d wrap=%0b", a2_if.q, a2_if.wrap, m2q, m2wrap);
            end
        end
        a2_if.en = 1'b0;
    endtask

    task automatic test_natural_wrap();
        a16_if.en = 1'b1; a16_if.up = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick_aux();
            checks++;
            if (a16_if.q !== 4'((i + 1) % 16) || a16_if.wrap !== (i == 15)) begin
                errors++; $display("[TB] FAIL m16_up: got q=%0d wrap=%0b expected q=%0d wrap=%0b",
                                   a16_if.q, a16_if.wrap, (i + 1) % 16, (i == 15));
            end
        end
        a16_if.up = 1'b0;
        tick_aux();
        checks++;
        if (a16_if.q !== 4'd15 || a16_if.wrap !== 1'b1) begin
            errors++; $display("[TB] FAIL m16_down: got q=%0d wrap=%0b expected q=15 wrap=1", a16_if.q, a16_if.wrap);
        end
        checks++;
        if (a16_if.q !== 4'(m16q) || a16_if.wrap !== m16wrap) begin
            errors++; $display("[TB] FAIL m16_model: got q=%0d expected %0d", a16_if.q, m16q);
        end
        a16_if.en = 1'b0;
    endtask

    task automatic test_cascade();
        int cnt;
        c_rst_n = 1'b0;
        lo_if.en = 1'b1; lo_if.up = 1'b1; lo_if.load = 1'b0; lo_if.d = 4'd0;
        hi_if.up = 1'b1; hi_if.load = 1'b0; hi_if.d = 4'd0;
        tick_c();
        c_rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick_c();
            cnt = (i + 1) % 100;
            checks++;
            if (hi_if.q !== 4'(cnt / 10) || lo_if.q !== 4'(cnt % 10)) begin
                errors++; $display("[TB] FAIL cascade: got %0d%0d expected %0d", hi_if.q, lo_if.q, cnt);
            end
        end
        checks++;
        if (hi_if.wrap !== 1'b1 || lo_if.wrap !== 1'b1) begin
            errors++; $display("[TB] FAIL cascade_wrap: got hi=%0b lo=%0b expected 1/1", hi_if.wrap, lo_if.wrap);
        end
        lo_if.en = 1'b0;
    endtask

`ifdef JK_EXCITE_OUT_EN
    task automatic test_excite();
        m_if.load = 1'b1; m_if.d = 4'd3; m_if.en = 1'b0;
        tick();
        m_if.load = 1'b0; m_if.en = 1'b1; m_if.up = 1'b1;
        tick();
        checks++;
        if (m_if.q !== 4'd4 || m_if.j_vec !== 4'b0100 || m_if.k_vec !== 4'b0011) begin
            errors++; $display("[TB] FAIL excite_3to4: got q=%0d j=%b k=%b expected q=4 j=0100 k=0011",
                               m_if.q, m_if.j_vec, m_if.k_vec);
        end
        m_if.en = 1'b0;
        tick();
        checks++;
        if (m_if.j_vec !== 4'b0000 || m_if.k_vec !== 4'b0000) begin
            errors++; $display("[TB] FAIL excite_hold: got j=%b k=%b expected 0000/0000", m_if.j_vec, m_if.k_vec);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; aux_rst_n = 1'b0; c_rst_n = 1'b0;
        m_if.en = 1'b0;   m_if.up = 1'b1;   m_if.load = 1'b0;   m_if.d = 4'd0;
        a2_if.en = 1'b0;  a2_if.up = 1'b1;  a2_if.load = 1'b0;  a2_if.d = 4'd0;
        a16_if.en = 1'b0; a16_if.up = 1'b1; a16_if.load = 1'b0; a16_if.d = 4'd0;
        lo_if.en = 1'b0;  lo_if.up = 1'b1;  lo_if.load = 1'b0;  lo_if.d = 4'd0;
        hi_if.up = 1'b1;  hi_if.load = 1'b0; hi_if.d = 4'd0;
        mq = 0; mwrap = 1'b0; m2q = 0; m2wrap = 1'b0; m16q = 0; m16wrap = 1'b0;
        @(negedge clk);

        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_reset_priority();
`ifdef JK_EXCITE_OUT_EN
        test_excite();
`endif
        test_random();
        test_back_to_back();
        test_natural_wrap();
        test_cascade();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
